dtree_seq_ctrl: RTL

DTREE_SEQ_CTRL -- requirements
Module: dtree_seq_ctrl

---
 rtl/dtree_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dtree_seq_ctrl.sv
// Decision-tree inference sequencer: buffers one feature vector, then walks a
// node table held in an external synchronous ROM until a leaf or the depth limit.
module dtree_seq_ctrl #(
    parameter int NUM_FEAT  = 16,
    parameter int FEAT_W    = 8,
    parameter int NODE_AW   = 6,
    parameter int CLASS_W   = 4,
    parameter int MAX_DEPTH = 15,
    localparam int FIDX_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
    localparam int NODE_W   = 1 + FIDX_W + FEAT_W + NODE_AW,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FEAT_W-1:0]  in_feat,
    output logic [NODE_AW-1:0] node_addr,
    input  logic [NODE_W-1:0]  node_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err
);

    typedef enum logic [1:0] {S_LOAD, S_FETCH, S_EVAL, S_RESULT} state_t;

    state_t               r_state, w_state_nxt;
    logic [FIDX_W-1:0]    r_beat_cnt, w_beat_nxt;
    logic [DEPTH_W-1:0]   r_depth, w_depth_nxt;
    logic [NODE_AW-1:0]   r_node_addr, w_addr_nxt;
    logic [CLASS_W-1:0]   r_class, w_class_nxt;
    logic                 r_err, w_err_nxt;
    logic [FEAT_W-1:0]    r_feat [NUM_FEAT];

    logic                 w_beat_acc;
    logic                 w_leaf;
    logic [FIDX_W-1:0]    w_fidx;
    logic [FEAT_W-1:0]    w_thr;
    logic [NODE_AW-1:0]   w_child;
    logic [CLASS_W-1:0]   w_leaf_cls;
    logic [FEAT_W-1:0]    w_fval;

    assign w_beat_acc = in_valid && (r_state == S_LOAD);
    assign w_leaf     = node_data[NODE_W-1];
    assign w_fidx     = node_data[NODE_W-2 -: FIDX_W];
    assign w_thr      = node_data[NODE_AW +: FEAT_W];
    assign w_child    = node_data[NODE_AW-1:0];
    assign w_leaf_cls = node_data[CLASS_W-1:0];

    // Indices past the buffer only exist when NUM_FEAT is not a power of two;
    // those read as zero.
    generate
        if (NUM_FEAT == (1 << FIDX_W)) begin : g_fsel_full
            assign w_fval = r_feat[w_fidx];
        end else begin : g_fsel_part
            assign w_fval = (int'(w_fidx) < NUM_FEAT) ? r_feat[w_fidx] : '0;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_depth_nxt = r_depth;
        w_addr_nxt  = r_node_addr;
        w_class_nxt = r_class;
        w_err_nxt   = r_err;
        case (r_state)
            S_LOAD: begin
                if (in_valid) begin
                    if (r_beat_cnt == FIDX_W'(NUM_FEAT - 1)) begin
                        w_beat_nxt  = '0;
                        w_addr_nxt  = '0;
                        w_depth_nxt = '0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_beat_nxt = r_beat_cnt + FIDX_W'(1);
                    end
                end
            end
            S_FETCH: w_state_nxt = S_EVAL;
            S_EVAL: begin
                if (w_leaf) begin
                    w_class_nxt = w_leaf_cls;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_RESULT;
                end else if (r_depth == DEPTH_W'(MAX_DEPTH - 1)) begin
                    // Depth budget exhausted: report the all-ones class flagged as error.
                    w_class_nxt = '1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESULT;
                end else begin
                    w_addr_nxt  = (w_fval <= w_thr) ? w_child : w_child + NODE_AW'(1);
                    w_depth_nxt = r_depth + DEPTH_W'(1);
                    w_state_nxt = S_FETCH;
                end
            end
            S_RESULT: if (out_ready) w_state_nxt = S_LOAD;
            default:  w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_beat_cnt  <= '0;
            r_depth     <= '0;
            r_node_addr <= '0;
            r_class     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_depth     <= w_depth_nxt;
            r_node_addr <= w_addr_nxt;
            r_class     <= w_class_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Feature buffer carries no reset; every sample rewrites all entries.
    always_ff @(posedge clk) begin
        if (w_beat_acc) r_feat[r_beat_cnt] <= in_feat;
    end

    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_RESULT);
    assign node_addr = r_node_addr;
    assign out_class = r_class;
    assign out_err   = r_err;

endmodule
